// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// FSM states, ALU ops, opcodes/functs, mux select codes, instruction class.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic rtype;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic illegal;
  } icls_t;

endpackage

// File: rtl/mc_ctrl_fsm_instr_decode.sv
// Combinational op/funct decode into a one-hot instruction class.
// Ports: i_op, i_funct in; o_cls, o_rt_aluop, o_shift_swap out.
module mc_instr_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output icls_t      o_cls,
  output logic [2:0] o_rt_aluop,
  output logic       o_shift_swap
);

  always_comb begin
    o_cls        = '0;
    o_rt_aluop   = ALU_ADD;
    o_shift_swap = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_cls.rtype = 1'b1;
        case (i_funct)
          FN_ADDU: o_rt_aluop = ALU_ADD;
          FN_SUBU: o_rt_aluop = ALU_SUB;
          FN_AND:  o_rt_aluop = ALU_AND;
          FN_OR:   o_rt_aluop = ALU_OR;
          FN_SRLV: begin
            o_rt_aluop   = ALU_SRL;
            o_shift_swap = 1'b1;
          end
          FN_SRAV: begin
            o_rt_aluop   = ALU_SRA;
            o_shift_swap = 1'b1;
          end
          default: begin
            o_cls.rtype   = 1'b0;
            o_cls.illegal = 1'b1;
          end
        endcase
      end
      OP_ORI:  o_cls.ori     = 1'b1;
      OP_LUI:  o_cls.lui     = 1'b1;
      OP_LW:   o_cls.lw      = 1'b1;
      OP_SW:   o_cls.sw      = 1'b1;
      OP_BEQ:  o_cls.beq     = 1'b1;
      OP_J:    o_cls.j       = 1'b1;
      default: o_cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXE/MEM/WB sequencing.
// Ports: clk, reset, op, funct, zero in; ALU/mux selects, write enables,
// InstrDone and Illegal pulses out. All outputs are 0 while reset is high.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter bit RESET_PC_WRITE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ExtOp,
  output logic       ShiftSwap,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       MemWrite,
  output logic       InstrDone,
  output logic       Illegal
);

  state_t     r_state;
  state_t     w_next;
  icls_t      w_cls;
  logic [2:0] w_rt_aluop;
  logic       w_swap;

  mc_instr_decode u_dec (
    .i_op         (op),
    .i_funct      (funct),
    .o_cls        (w_cls),
    .o_rt_aluop   (w_rt_aluop),
    .o_shift_swap (w_swap)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = S_FETCH;
    ALUOp     = ALU_ADD;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REGB;
    ExtOp     = EXT_ZERO;
    ShiftSwap = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = PC_ALU;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    MemWrite  = 1'b0;
    InstrDone = 1'b0;
    Illegal   = 1'b0;
    if (reset) begin
      PCWrite  = RESET_PC_WRITE;
      IRWrite  = RESET_PC_WRITE;
      RegWrite = RESET_PC_WRITE;
      MemWrite = RESET_PC_WRITE;
    end else begin
      case (r_state)
        S_FETCH: begin
          IRWrite = 1'b1;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
          w_next  = S_DECODE;
        end
        S_DECODE: begin
          // Branch target is computed here speculatively into ALUOut.
          ALUSrcB = SRCB_BOFF;
          if (w_cls.j) begin
            PCSrc     = PC_JUMP;
            PCWrite   = 1'b1;
            InstrDone = 1'b1;
          end else if (w_cls.illegal) begin
            Illegal   = 1'b1;
            InstrDone = 1'b1;
          end else begin
            w_next = S_EXE;
          end
        end
        S_EXE: begin
          unique case (1'b1)
            w_cls.rtype: begin
              ALUSrcA   = 1'b1;
              ALUOp     = w_rt_aluop;
              ShiftSwap = w_swap;
              w_next    = S_WB;
            end
            w_cls.ori: begin
              ALUSrcB = SRCB_IMM;
              ALUOp   = ALU_OR;
              w_next  = S_WB;
            end
            w_cls.lui: begin
              // rs is $0, so OR passes the shifted immediate through.
              ExtOp   = EXT_LUI;
              ALUSrcB = SRCB_IMM;
              ALUSrcA = 1'b1;
              ALUOp   = ALU_OR;
              w_next  = S_WB;
            end
            w_cls.lw, w_cls.sw: begin
              ExtOp   = EXT_SIGN;
              ALUSrcB = SRCB_IMM;
              w_next  = S_MEM;
            end
            w_cls.beq: begin
              ALUSrcA   = 1'b1;
              ALUOp     = ALU_SUB;
              PCSrc     = PC_ALUOUT;
              PCWrite   = zero;
              InstrDone = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (w_cls.sw) begin
            MemWrite  = 1'b1;
            InstrDone = 1'b1;
          end else if (w_cls.lw) begin
            w_next = S_WB;
          end
        end
        S_WB: begin
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
          RegDst    = w_cls.rtype;
          MemtoReg  = w_cls.lw;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: directed per-cycle vectors with
// hand-written expected output bundles, checked by a separate monitor.
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic [2:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] ext;
    logic       swap;
    logic       pcw;
    logic [1:0] pcsrc;
    logic       irw;
    logic       rw;
    logic       rdst;
    logic       m2r;
    logic       mw;
    logic       done;
    logic       ill;
  } ov_t;

  localparam ov_t V_Z   = '0;
  localparam ov_t V_F   = '{srcb:2'b01, pcw:1'b1, irw:1'b1, default:'0};
  localparam ov_t V_D   = '{srcb:2'b11, default:'0};
  localparam ov_t V_DJ  = '{srcb:2'b11, pcw:1'b1, pcsrc:2'b10,
                            done:1'b1, default:'0};
  localparam ov_t V_DIL = '{srcb:2'b11, done:1'b1, ill:1'b1, default:'0};
  localparam ov_t V_EAD = '{srca:1'b1, default:'0};
  localparam ov_t V_ESR = '{aluop:3'b101, srca:1'b1, swap:1'b1, default:'0};
  localparam ov_t V_EMA = '{srcb:2'b10, ext:2'b01, default:'0};
  localparam ov_t V_EOR = '{aluop:3'b011, srcb:2'b10, default:'0};
  localparam ov_t V_ELU = '{aluop:3'b011, srca:1'b1, srcb:2'b10,
                            ext:2'b10, default:'0};
  localparam ov_t V_EBT = '{aluop:3'b001, srca:1'b1, pcw:1'b1,
                            pcsrc:2'b01, done:1'b1, default:'0};
  localparam ov_t V_EBN = '{aluop:3'b001, srca:1'b1, pcsrc:2'b01,
                            done:1'b1, default:'0};
  localparam ov_t V_MSW = '{mw:1'b1, done:1'b1, default:'0};
  localparam ov_t V_WR  = '{rw:1'b1, rdst:1'b1, done:1'b1, default:'0};
  localparam ov_t V_WI  = '{rw:1'b1, done:1'b1, default:'0};
  localparam ov_t V_WLW = '{rw:1'b1, m2r:1'b1, done:1'b1, default:'0};

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ExtOp;
  logic       ShiftSwap;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       MemWrite;
  logic       InstrDone;
  logic       Illegal;

  ov_t   act;
  ov_t   exp_q[$];
  string nm_q[$];
  int    errors = 0;
  int    checks = 0;

  mc_ctrl_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .ALUOp     (ALUOp),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ExtOp     (ExtOp),
    .ShiftSwap (ShiftSwap),
    .PCWrite   (PCWrite),
    .PCSrc     (PCSrc),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .MemWrite  (MemWrite),
    .InstrDone (InstrDone),
    .Illegal   (Illegal)
  );

  assign act = {ALUOp, ALUSrcA, ALUSrcB, ExtOp, ShiftSwap, PCWrite,
                PCSrc, IRWrite, RegWrite, RegDst, MemtoReg, MemWrite,
                InstrDone, Illegal};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ov_t   e;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got=%05h want=%05h", n, act, e);
      end
    end
  end

  task automatic cyc(input logic rst, input logic [5:0] o,
                     input logic [5:0] f, input logic z,
                     input ov_t e, input string n);
    reset = rst;
    op    = o;
    funct = f;
    zero  = z;
    exp_q.push_back(e);
    nm_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    op    = 6'b100011;
    funct = 6'b0;
    zero  = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 6'b100011, 6'd0, 0, V_Z, "reset0");
    cyc(1, 6'b100011, 6'd0, 1, V_Z, "reset1");
    // addu
    cyc(0, 6'd0, 6'b100001, 0, V_F,   "addu_F");
    cyc(0, 6'd0, 6'b100001, 0, V_D,   "addu_D");
    cyc(0, 6'd0, 6'b100001, 0, V_EAD, "addu_E");
    cyc(0, 6'd0, 6'b100001, 0, V_WR,  "addu_W");
    // srav
    cyc(0, 6'd0, 6'b000111, 0, V_F,   "srav_F");
    cyc(0, 6'd0, 6'b000111, 0, V_D,   "srav_D");
    cyc(0, 6'd0, 6'b000111, 0, V_ESR, "srav_E");
    cyc(0, 6'd0, 6'b000111, 0, V_WR,  "srav_W");
    // lw
    cyc(0, 6'b100011, 6'd5, 0, V_F,   "lw_F");
    cyc(0, 6'b100011, 6'd5, 0, V_D,   "lw_D");
    cyc(0, 6'b100011, 6'd5, 0, V_EMA, "lw_E");
    cyc(0, 6'b100011, 6'd5, 0, V_Z,   "lw_M");
    cyc(0, 6'b100011, 6'd5, 0, V_WLW, "lw_W");
    // beq taken then not taken
    cyc(0, 6'b000100, 6'd0, 1, V_F,   "beqT_F");
    cyc(0, 6'b000100, 6'd0, 1, V_D,   "beqT_D");
    cyc(0, 6'b000100, 6'd0, 1, V_EBT, "beqT_E");
    cyc(0, 6'b000100, 6'd0, 0, V_F,   "beqN_F");
    cyc(0, 6'b000100, 6'd0, 0, V_D,   "beqN_D");
    cyc(0, 6'b000100, 6'd0, 0, V_EBN, "beqN_E");
    // ori, lui, j
    cyc(0, 6'b001101, 6'd0, 0, V_F,   "ori_F");
    cyc(0, 6'b001101, 6'd0, 0, V_D,   "ori_D");
    cyc(0, 6'b001101, 6'd0, 0, V_EOR, "ori_E");
    cyc(0, 6'b001101, 6'd0, 0, V_WI,  "ori_W");
    cyc(0, 6'b001111, 6'd0, 0, V_F,   "lui_F");
    cyc(0, 6'b001111, 6'd0, 0, V_D,   "lui_D");
    cyc(0, 6'b001111, 6'd0, 0, V_ELU, "lui_E");
    cyc(0, 6'b001111, 6'd0, 0, V_WI,  "lui_W");
    cyc(0, 6'b000010, 6'd0, 0, V_F,   "j_F");
    cyc(0, 6'b000010, 6'd0, 0, V_DJ,  "j_D");
    // illegal opcode and illegal R-type funct
    cyc(0, 6'b111111, 6'd0, 0, V_F,   "ill_F");
    cyc(0, 6'b111111, 6'd0, 0, V_DIL, "ill_D");
    cyc(0, 6'd0, 6'b111111, 0, V_F,   "illr_F");
    cyc(0, 6'd0, 6'b111111, 0, V_DIL, "illr_D");
    // full sw
    cyc(0, 6'b101011, 6'd0, 0, V_F,   "sw_F");
    cyc(0, 6'b101011, 6'd0, 0, V_D,   "sw_D");
    cyc(0, 6'b101011, 6'd0, 0, V_EMA, "sw_E");
    cyc(0, 6'b101011, 6'd0, 0, V_MSW, "sw_M");
    // sw aborted by reset in MEM
    cyc(0, 6'b101011, 6'd0, 0, V_F,   "swA_F");
    cyc(0, 6'b101011, 6'd0, 0, V_D,   "swA_D");
    cyc(0, 6'b101011, 6'd0, 0, V_EMA, "swA_E");
    cyc(1, 6'b101011, 6'd0, 0, V_Z,   "swA_Mrst");
    cyc(0, 6'b101011, 6'd0, 0, V_F,   "swA_post_F");
    cyc(0, 6'b101011, 6'd0, 0, V_D,   "swA_post_D");
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got=%0d want=0 pending", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS control unit: the initiator side of the ALU interface.
- Decodes op/funct held in the external IR and sequences FETCH/DECODE/EXE/MEM/WB.
- Drives ALUOp, datapath mux selects and write enables for the PC, IR, GPR file and DM.
- Consumes the Zero flag (ALU C == 0), which the datapath computes.

Parameters:
- RESET_PC_WRITE, 0, value of every write enable while reset is high. Fixed 0; present only for documentation.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU result == 0
- ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 logical right shift A>>B, 101 arithmetic right shift
- ALUSrcA  out  1  0=PC, 1=reg A
- ALUSrcB  out  2  00=reg B, 01=const 4, 10=extended imm, 11=sign-ext imm<<2
- ExtOp  out  2  00 zero-ext, 01 sign-ext, 10 imm<<16
- ShiftSwap  out  1  1: ALU A=reg B(rt), ALU B={27'b0, reg A[4:0]} (rs)
- PCWrite  out  1  PC load enable
- PCSrc  out  2  00 ALU C, 01 ALUOut, 10 {PC[31:28], IR[25:0], 2'b00}
- IRWrite  out  1  IR load enable
- RegWrite  out  1  GPR write enable
- RegDst  out  1  0=rt, 1=rd
- MemtoReg  out  1  0=ALUOut, 1=MDR
- MemWrite  out  1  DM write enable
- InstrDone  out  1  one-cycle pulse in the last state of each instruction
- Illegal  out  1  one-cycle pulse in DECODE for an unsupported encoding

Behaviour:
- States: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. State register only; all outputs are combinational from state, op, funct and zero.
- Reset: state<=FETCH on the clk edge with reset=1.
  - While reset=1 all outputs are 0 (ALUOp=000).
  - Reset mid-instruction aborts it with no further writes.
- Supported instructions:
  - R-type (op=000000): addu 100001, subu 100011, and 100100, or 100101, srlv 000110, srav 000111.
  - ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010.
- Outputs not listed for a state are 0.
- FETCH:
  - IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSrc=00, PCWrite=1.
  - Next state: DECODE.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=add; the datapath latches the branch target into ALUOut.
  - j: PCSrc=10, PCWrite=1, InstrDone=1, next FETCH.
  - Illegal: Illegal=1, InstrDone=1, next FETCH (executes as nop).
  - Otherwise: next EXE.
- EXE:
  - R-type: ALUSrcA=1, ALUSrcB=00, ALUOp per funct (srlv->100, srav->101, both with ShiftSwap=1); next WB.
  - ori: ExtOp=00, ALUSrcB=10, ALUOp=or; next WB.
  - lui: ExtOp=10, ALUSrcB=10, ALUOp=or, ALUSrcA=1 (rs=$0 by ISA); next WB.
  - lw/sw: ExtOp=01, ALUSrcB=10, ALUOp=add; next MEM.
  - beq: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCSrc=01, PCWrite=zero, InstrDone=1; next FETCH.
- MEM:
  - sw: MemWrite=1, InstrDone=1, next FETCH.
  - lw: next WB (MDR latched by the datapath).
- WB:
  - RegWrite=1, InstrDone=1, next FETCH.
  - RegDst=1 for R-type, else 0. MemtoReg=1 for lw only.
- Latency in cycles: j/illegal 2, beq 3, sw 4, R/ori/lui 4, lw 5.
- Exactly one InstrDone pulse per instruction.
- Unused state encodings 5-7 go to FETCH with all outputs 0.
- op/funct are sampled every cycle. IR is stable after FETCH because IRWrite=0 elsewhere.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings;
  - ALUOp constants ALU_ADD..ALU_SRA (000-101, must match the ALU);
  - opcode/funct constants;
  - ALUSrcB/ExtOp/PCSrc select codes.
- One sub-module, mc_instr_decode: combinational op/funct -> one-hot instruction class (rtype_alu, ori, lui, lw, sw, beq, j, illegal) plus the R-type ALUOp/ShiftSwap.

Test Plan:
- reset=1 for 2 cycles, then released -> all outputs 0 during reset; the first cycle after release is FETCH with IRWrite=1, PCWrite=1, ALUOp=000, ALUSrcB=01.
- addu (op=0, funct=100001) -> 4 cycles; RegWrite=1 and RegDst=1 in cycle 4 only; InstrDone pulses once.
- srav (funct=000111) -> in EXE, ALUOp=101 and ShiftSwap=1; then WB with RegWrite=1.
- lw (op=100011) -> EXE ALUOp=000, ExtOp=01, ALUSrcB=10; MEM no writes; WB RegWrite=1, MemtoReg=1, RegDst=0; 5 cycles total.
- beq with zero=1, then zero=0 -> EXE ALUOp=001, PCSrc=01, PCWrite=1 (taken), PCWrite=0 (not taken); back to FETCH.
- op=111111, then reset asserted in MEM of a sw -> Illegal=1 for one cycle, no writes; after reset, MemWrite is never asserted and the next state is FETCH.
